rom_port_arbiter: RTL and testbench

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

---
 rtl/rom_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 32 +++
 rtl/rom_port_arbiter.sv | 125 ++++++++++++
 tb/tb_rom_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared defaults and state encoding for the ROM port B arbiter
package rom_arb_pkg;

    localparam int DEF_NUM_REQ    = 3;
    localparam int DEF_ADDR_WIDTH = 15;
    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_ROM_SIZE   = 19200;
    localparam int DEF_LEN_WIDTH  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Width of an index into a requester vector; never zero, even for one requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting after the last winner
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    // Scan last_winner+1, +2, ... wrapping; the first active request wins.
    always_comb begin
        int p;
        p          = 0;
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            p = (int'(last_winner) + k) % NUM_REQ;
            if (!valid && req[p]) begin
                valid      = 1'b1;
                winner[p]  = 1'b1;
                winner_idx = IDX_W'(p);
            end
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - round-robin burst arbiter for the shared ROM read port B
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROM_SIZE   = DEF_ROM_SIZE,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         rom_addr_b,
    input  logic [DATA_WIDTH-1:0]         rom_q_b
);

    localparam int                    IDX_W     = idx_width(NUM_REQ);
    localparam logic [ADDR_WIDTH:0]   SIZE_EXT  = (ADDR_WIDTH+1)'(ROM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROM_SIZE - 1);

    arb_state_e            state, state_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [LEN_WIDTH-1:0]  beats_left, beats_left_d;
    logic [NUM_REQ-1:0]    owner, owner_d;
    logic [IDX_W-1:0]      last_winner, last_winner_d;
    logic [NUM_REQ-1:0]    gnt_d;
    logic [NUM_REQ-1:0]    rvalid_d;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic [ADDR_WIDTH-1:0] sel_addr_mapped;
    logic [ADDR_WIDTH-1:0] next_addr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req         (req),
        .last_winner (last_winner),
        .winner      (pick_onehot),
        .winner_idx  (pick_idx),
        .valid       (pick_valid)
    );

    assign sel_addr = req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_len  = req_len[int'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];

    // Out-of-range start addresses fall back to word 0 rather than aliasing.
    assign sel_addr_mapped = ({1'b0, sel_addr} >= SIZE_EXT) ? '0 : sel_addr;

    // The ROM is not a power of two deep, so the beat address wraps explicitly.
    assign next_addr = (rom_addr_b == LAST_ADDR) ? '0 : rom_addr_b + ADDR_WIDTH'(1);

    // Read data is the ROM output as-is; rvalid says when it belongs to a beat.
    assign rdata = rom_q_b;
    assign busy  = (state == ST_BURST);

    // State register: all outputs are registered copies of the next-state values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rom_addr_b  <= '0;
            beats_left  <= '0;
            owner       <= '0;
            last_winner <= IDX_W'(NUM_REQ - 1);
            gnt         <= '0;
            rvalid      <= '0;
        end else begin
            state       <= state_d;
            rom_addr_b  <= addr_d;
            beats_left  <= beats_left_d;
            owner       <= owner_d;
            last_winner <= last_winner_d;
            gnt         <= gnt_d;
            rvalid      <= rvalid_d;
        end
    end

    // Next-state logic: grant from IDLE, then issue one address per BURST cycle.
    always_comb begin
        state_d       = state;
        addr_d        = rom_addr_b;
        beats_left_d  = beats_left;
        owner_d       = owner;
        last_winner_d = last_winner;
        gnt_d         = '0;
        rvalid_d      = '0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d       = ST_BURST;
                    addr_d        = sel_addr_mapped;
                    beats_left_d  = sel_len;
                    owner_d       = pick_onehot;
                    last_winner_d = pick_idx;
                    gnt_d         = pick_onehot;
                end
            end
            ST_BURST: begin
                // The address issued this cycle returns data next cycle.
                rvalid_d = owner;
                if (beats_left == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    beats_left_d = beats_left - LEN_WIDTH'(1);
                    addr_d       = next_addr;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - self-checking bench for rom_port_arbiter
module tb_rom_port_arbiter;

    localparam int NR   = 3;
    localparam int AW   = 15;
    localparam int DW   = 24;
    localparam int RS   = 19200;
    localparam int LW   = 4;
    localparam int MAXC = 8192;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_len;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    rvalid;
    logic [DW-1:0]    rdata;
    logic             busy;
    logic [AW-1:0]    rom_addr_b;
    logic [DW-1:0]    rom_q_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    rom_port_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ROM_SIZE   (RS),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .busy       (busy),
        .rom_addr_b (rom_addr_b),
        .rom_q_b    (rom_q_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {a[8:0], a ^ 15'h2A5C};
    endfunction

    // ROM port B: one-cycle synchronous read
    always @(posedge clk) rom_q_b <= rom_word(rom_addr_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected per-cycle outputs; cycle c is the interval after rising edge c.
    logic [NR-1:0] e_gnt  [MAXC];
    logic [NR-1:0] e_rv   [MAXC];
    logic          e_busy [MAXC];
    logic [AW-1:0] e_addr [MAXC];
    logic [DW-1:0] e_data [MAXC];
    bit            a_set  [MAXC];

    // Reference model: on each grant, lay out the whole burst's timeline ahead.
    initial begin
        int c, w, ln, base, free_at, m_last;
        logic [AW-1:0] st, a;
        for (int i = 0; i < MAXC; i++) begin
            e_gnt[i] = '0; e_rv[i] = '0; e_busy[i] = 1'b0;
            e_addr[i] = '0; e_data[i] = '0; a_set[i] = 1'b0;
        end
        free_at = 0;
        m_last  = NR - 1;
        forever begin
            @(posedge clk);
            cyc++;
            c = cyc;
            if (!rst_n) begin
                for (int k = c; k < c + 20; k++) begin
                    e_gnt[k] = '0; e_rv[k] = '0; e_busy[k] = 1'b0;
                    e_addr[k] = '0; a_set[k] = 1'b0;
                end
                a_set[c] = 1'b1;
                m_last   = NR - 1;
                free_at  = c + 1;
            end else begin
                if (!a_set[c]) e_addr[c] = e_addr[c-1];
                if (c >= free_at && req != '0) begin
                    w = -1;
                    for (int k = 1; k <= NR; k++)
                        if (w < 0 && req[(m_last + k) % NR]) w = (m_last + k) % NR;
                    st   = req_addr[w*AW +: AW];
                    ln   = int'(req_len[w*LW +: LW]);
                    base = (int'(st) >= RS) ? 0 : int'(st);
                    for (int k = 0; k <= ln; k++) begin
                        a = AW'((base + k) % RS);
                        e_busy[c+k]   = 1'b1;
                        e_addr[c+k]   = a;
                        a_set[c+k]    = 1'b1;
                        e_rv[c+k+1]   = NR'(1 << w);
                        e_data[c+k+1] = rom_word(a);
                    end
                    e_gnt[c] = NR'(1 << w);
                    m_last   = w;
                    free_at  = c + ln + 2;
                end
            end
        end
    end

    // Compare process: every cycle once reset has been applied
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("busy", 32'(busy), 32'(e_busy[cyc]));
                chk("gnt", 32'(gnt), 32'(e_gnt[cyc]));
                chk("rvalid", 32'(rvalid), 32'(e_rv[cyc]));
                chk("rom_addr_b", 32'(rom_addr_b), 32'(e_addr[cyc]));
                if (e_rv[cyc] != '0) chk("rdata", 32'(rdata), 32'(e_data[cyc]));
            end
        end
    end

    task automatic wait_gnt(input int who, input int limit, output bit got);
        got = 1'b0;
        for (int t = 0; t < limit && !got; t++) begin
            @(negedge clk);
            if (gnt[who]) got = 1'b1;
        end
    endtask

    task automatic burst_expect(input int who, input logic [AW-1:0] a, input logic [LW-1:0] l,
                                input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                                input logic [AW-1:0] e2, input logic [AW-1:0] e3);
        logic [AW-1:0] ev[4];
        bit got;
        int nrv;
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        req_addr[who*AW +: AW] = a;
        req_len[who*LW +: LW]  = l;
        req[who] = 1'b1;
        wait_gnt(who, 40, got);
        chk("burst_gnt_seen", 32'(got), 32'd1);
        req[who] = 1'b0;
        nrv = 0;
        for (int k = 0; k <= int'(l) + 2; k++) begin
            if (k > 0) @(negedge clk);
            if (k <= int'(l) && k < 4) chk("burst_addr", 32'(rom_addr_b), 32'(ev[k]));
            if (rvalid[who]) nrv++;
        end
        chk("burst_rvalid_count", 32'(nrv), 32'(int'(l) + 1));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int g_cyc[$];
        logic [NR-1:0] g_vec[$];
        int g0, g2;
        bit got;
        rst_n = 1'b0; req = '0; req_addr = '0; req_len = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_addr", 32'(rom_addr_b), 32'd0);
        rst_n = 1'b1;

        // contention straight out of reset, all single-beat
        req_addr = {15'h0300, 15'h0200, 15'h0100};
        req_len  = '0;
        req      = 3'b111;
        for (int t = 0; t < 40 && g_cyc.size() < 4; t++) begin
            @(negedge clk);
            if (gnt != '0) begin
                g_cyc.push_back(cyc);
                g_vec.push_back(gnt);
            end
        end
        req = '0;
        chk("contention_grants", 32'(g_cyc.size()), 32'd4);
        if (g_cyc.size() == 4) begin
            chk("contention_g0", 32'(g_vec[0]), 32'b001);
            chk("contention_g1", 32'(g_vec[1]), 32'b010);
            chk("contention_g2", 32'(g_vec[2]), 32'b100);
            chk("contention_g3", 32'(g_vec[3]), 32'b001);
            for (int i = 1; i < 4; i++)
                chk("contention_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd2);
        end
        repeat (4) @(negedge clk);

        burst_expect(0, 15'h0010, 4'd3, 15'h0010, 15'h0011, 15'h0012, 15'h0013);
        burst_expect(1, 15'd19198, 4'd3, 15'd19198, 15'd19199, 15'd0, 15'd1);
        burst_expect(1, 15'h7FFF, 4'd0, 15'd0, 15'd0, 15'd0, 15'd0);

        // late request from requester 2 while requester 0 is bursting
        req_addr[0 +: AW] = 15'h0040; req_len[0 +: LW] = 4'd3; req[0] = 1'b1;
        wait_gnt(0, 40, got);
        chk("late_gnt0_seen", 32'(got), 32'd1);
        g0 = cyc;
        req[0] = 1'b0;
        @(negedge clk);
        req_addr[2*AW +: AW] = 15'h0050; req_len[2*LW +: LW] = 4'd0; req[2] = 1'b1;
        wait_gnt(2, 40, got);
        chk("late_gnt2_seen", 32'(got), 32'd1);
        g2 = cyc;
        req[2] = 1'b0;
        chk("late_gnt2_delay", 32'(g2 - g0), 32'd5);
        repeat (4) @(negedge clk);

        // reset on beat 5 of a 16-beat burst from requester 0
        req_addr[0 +: AW] = 15'h0100; req_len[0 +: LW] = 4'd15; req[0] = 1'b1;
        wait_gnt(0, 40, got);
        chk("rst_gnt0_seen", 32'(got), 32'd1);
        req[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
        chk("rst_mid_addr", 32'(rom_addr_b), 32'd0);
        rst_n = 1'b1;
        req_addr[0 +: AW] = 15'h0200; req_addr[AW +: AW] = 15'h0300;
        req_len[0 +: LW] = 4'd1; req_len[LW +: LW] = 4'd1;
        req[1:0] = 2'b11;
        @(negedge clk);
        chk("rst_next_gnt", 32'(gnt), 32'b001);
        req[0] = 1'b0;
        wait_gnt(1, 40, got);
        chk("rst_gnt1_seen", 32'(got), 32'd1);
        req[1] = 1'b0;
        repeat (6) @(negedge clk);

        // randomized traffic with occasional resets
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < NR; i++) begin
                if (req[i] && gnt[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       req_addr[i*AW +: AW] = AW'($urandom_range(0, 32767));
                        1:       req_addr[i*AW +: AW] = AW'($urandom_range(19180, 19199));
                        default: req_addr[i*AW +: AW] = AW'($urandom_range(19200, 32767));
                    endcase
                    req_len[i*LW +: LW] = LW'($urandom_range(0, 15));
                    req[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
        req = '0;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
